// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared SoC widths and DMA loader state encoding
package soc_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WRITE,
        ACK_LOW,
        DONE
    } dma_state_t;
endpackage

// File: rtl/io_dma_loader.sv
// rtl/io_dma_loader.sv - 4-phase handshake requester that preloads memory; checksum built only with DMA_CHECKSUM_EN
module io_dma_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              inp_req,
    input  logic              inp_ack,
    input  logic [DATA_W-1:0] inp_data,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    import soc_pkg::*;

    dma_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remaining;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state     <= IDLE;
            inp_req   <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            addr_q    <= '0;
            remaining <= '0;
        end else begin
            mem_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                        end else begin
                            state   <= REQ;
                            inp_req <= 1'b1;
                        end
                    end
                end
                // An ack already high on entry is taken on the first edge.
                REQ: begin
                    if (inp_ack) begin
                        mem_din   <= inp_data;
                        inp_req   <= 1'b0;
                        mem_write <= 1'b1;
                        mem_addr  <= addr_q;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    addr_q    <= addr_q + 1'b1;
                    remaining <= remaining - 1'b1;
                    state     <= ACK_LOW;
                end
                // Return-to-zero: never raise req while the previous ack is still high.
                ACK_LOW: begin
                    if (!inp_ack) begin
                        if (remaining == '0) begin
                            state <= DONE;
                        end else begin
                            state   <= REQ;
                            inp_req <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (state == WRITE) begin
            sum_q <= sum_q + mem_din;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_io_dma_loader.sv
// tb/tb_io_dma_loader.sv - randomized self-checking bench for io_dma_loader against a write-sequence model
module tb_io_dma_loader;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] count = '0;
    logic          inp_req;
    logic          inp_ack;
    logic [DW-1:0] inp_data;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] stim_q[$];
    logic [DW-1:0] src_q[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    logic [DW-1:0] exp_ck;
    int            ack_dly = 0;
    int            rel_dly = 0;
    int            done_cnt = 0;
    int            req_rises = 0;
    int            req_rise_bad = 0;
    int            req_fall_bad = 0;
    logic          req_prev = 1'b0;
    logic          ack_prev = 1'b0;

    io_dma_loader dut (
        .clk(clk), .rst_b(rst_b), .start(start), .base_addr(base_addr), .count(count),
        .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // input_unit responder with programmable ack and release delays
    initial begin
        inp_ack = 1'b0;
        inp_data = '0;
        forever begin
            @(posedge clk); #1;
            if (inp_req && !inp_ack) begin
                repeat (ack_dly) begin @(posedge clk); #1; end
                if (src_q.size() > 0) inp_data = src_q.pop_front();
                else inp_data = 16'hdead;
                inp_ack = 1'b1;
                for (int i = 0; i < 5000 && inp_req; i++) begin @(posedge clk); #1; end
                repeat (rel_dly) begin @(posedge clk); #1; end
                inp_ack = 1'b0;
            end
        end
    end

    // Observation: write log, done pulses, handshake ordering
    always @(negedge clk) begin
        if (mem_write) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_din);
        end
        if (done) done_cnt++;
        if (inp_req && !req_prev) begin
            req_rises++;
            if (ack_prev) req_rise_bad++;
        end
        if (!inp_req && req_prev && !ack_prev && !rst_b) req_fall_bad++;
        req_prev = inp_req;
        ack_prev = inp_ack;
    end

    task automatic fill_random(input int c);
        stim_q.delete();
        for (int i = 0; i < c; i++) stim_q.push_back(DW'($urandom));
    endtask

    task automatic begin_load(input int b, input int c, input int ad, input int rd);
        logic [DW-1:0] sum;
        ack_dly = ad;
        rel_dly = rd;
        exp_addr.delete(); exp_data.delete(); log_addr.delete(); log_data.delete(); src_q.delete();
        done_cnt = 0; req_rises = 0; req_rise_bad = 0; req_fall_bad = 0;
        sum = '0;
        for (int i = 0; i < c; i++) begin
            exp_addr.push_back(AW'((b + i) % 512));
            exp_data.push_back(stim_q[i]);
            src_q.push_back(stim_q[i]);
            sum = sum + stim_q[i];
        end
`ifdef DMA_CHECKSUM_EN
        exp_ck = sum;
`else
        exp_ck = '0;
`endif
        for (int i = 0; i < 100 && inp_ack; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        base_addr = AW'(b);
        count = CW'(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin to = 1'b0; break; end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if ({inp_req, mem_write, busy, done, mem_addr, mem_din, checksum} !== '0) begin
            mismatched++;
            $display("FAIL reset_held: got %b/%b/%b/%b %h %h %h required all zero",
                     inp_req, mem_write, busy, done, mem_addr, mem_din, checksum);
        end
        @(posedge clk); #1;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({inp_req, mem_write, busy, done, checksum} !== '0) begin
            mismatched++;
            $display("FAIL reset_idle: got req=%b wr=%b busy=%b done=%b ck=%h required all zero",
                     inp_req, mem_write, busy, done, checksum);
        end
    endtask

    task automatic test_load3();
        bit to;
        stim_q.delete();
        stim_q.push_back(16'h1111); stim_q.push_back(16'h2222); stim_q.push_back(16'h3333);
        begin_load(12'h010, 3, 0, 0);
        wait_done(to);
        compared++;
        if (to) begin mismatched++; $display("FAIL load3_timeout: got no done required done"); end
        compared++;
        if (log_addr.size() != 3) begin
            mismatched++; $display("FAIL load3_writes: got %0d required 3", log_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            compared++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL load3_word%0d: got %h@%h required %h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        compared++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL load3_done: got %0d pulses busy=%b required 1 pulse busy=0", done_cnt, busy);
        end
        compared++;
        if (checksum !== exp_ck) begin
            mismatched++; $display("FAIL load3_checksum: got %h required %h", checksum, exp_ck);
        end
    endtask

    task automatic test_count_zero();
        stim_q.delete();
        begin_load(5, 0, 0, 0);
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            mismatched++; $display("FAIL zero_cycle1: got done=%b busy=%b required done=0 busy=1", done, busy);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL zero_cycle2: got done=%b busy=%b required done=1 busy=0", done, busy);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (req_rises != 0 || log_addr.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_quiet: got req=%0d writes=%0d done=%0d busy=%b required 0/0/1/0",
                     req_rises, log_addr.size(), done_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        bit to;
        stim_q.delete();
        stim_q.push_back(16'haaaa); stim_q.push_back(16'h5555);
        begin_load(12'h1ff, 2, 1, 1);
        wait_done(to);
        compared++;
        if (to || log_addr.size() != 2) begin
            mismatched++; $display("FAIL wrap_writes: got %0d writes timeout=%0d required 2", log_addr.size(), to);
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            compared++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL wrap_word%0d: got %h@%h required %h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_slow_responder();
        bit to;
        fill_random(3);
        begin_load($urandom_range(0, 511), 3, 5, 4);
        wait_done(to);
        compared++;
        if (to || req_rise_bad != 0 || req_fall_bad != 0 || req_rises != 3) begin
            mismatched++;
            $display("FAIL slow_handshake: got timeout=%0d rise_bad=%0d fall_bad=%0d reqs=%0d required 0/0/0/3",
                     to, req_rise_bad, req_fall_bad, req_rises);
        end
        compared++;
        if (log_addr.size() != 3 || checksum !== exp_ck) begin
            mismatched++; $display("FAIL slow_writes: got %0d ck=%h required 3 ck=%h", log_addr.size(), checksum, exp_ck);
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            compared++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL slow_word%0d: got %h@%h required %h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        fill_random(4);
        begin_load(12'h020, 4, 2, 2);
        repeat (4) @(posedge clk);
        #1;
        base_addr = 9'h100; count = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(to);
        compared++;
        if (to || log_addr.size() != 4 || done_cnt != 1) begin
            mismatched++;
            $display("FAIL busy_start: got %0d writes %0d done timeout=%0d required 4 writes 1 done", log_addr.size(), done_cnt, to);
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            compared++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL busy_word%0d: got %h@%h required %h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit to;
        bit hit;
        fill_random(4);
        begin_load(12'h0c0, 4, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (mem_write && mem_addr === exp_addr[1]) begin hit = 1'b1; break; end
        end
        rst_b = 1'b1;
        #1;
        compared++;
        if (!hit || {inp_req, mem_write, busy, done, mem_addr, mem_din, checksum} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: got hit=%0d req=%b wr=%b busy=%b addr=%h din=%h ck=%h required hit=1 all zero",
                     hit, inp_req, mem_write, busy, mem_addr, mem_din, checksum);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (log_addr.size() != 1 || log_addr[0] !== exp_addr[0] || log_data[0] !== exp_data[0]) begin
            mismatched++; $display("FAIL reset_kept: got %0d writes required 1 write of %h@%h", log_addr.size(), exp_data[0], exp_addr[0]);
        end
        fill_random(4);
        begin_load(12'h0c0, 4, 1, 0);
        wait_done(to);
        compared++;
        if (to || log_addr.size() != 4 || checksum !== exp_ck) begin
            mismatched++;
            $display("FAIL reset_reload: got %0d writes ck=%h timeout=%0d required 4 ck=%h", log_addr.size(), checksum, to, exp_ck);
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            compared++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL reload_word%0d: got %h@%h required %h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int c;
        for (int n = 0; n < 6; n++) begin
            c = $urandom_range(1, 8);
            fill_random(c);
            begin_load($urandom_range(0, 511), c, $urandom_range(0, 3), $urandom_range(0, 3));
            wait_done(to);
            compared++;
            if (to || log_addr.size() != c || done_cnt != 1 || checksum !== exp_ck || req_rise_bad != 0) begin
                mismatched++;
                $display("FAIL rand%0d_summary: got writes=%0d done=%0d ck=%h rise_bad=%0d to=%0d required %0d/1/%h/0/0",
                         n, log_addr.size(), done_cnt, checksum, req_rise_bad, to, c, exp_ck);
            end
            for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
                compared++;
                if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                    mismatched++;
                    $display("FAIL rand%0d_word%0d: got %h@%h required %h@%h", n, i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_count_zero();
        test_wrap();
        test_slow_responder();
        test_start_while_busy();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
